countdown_timer: RTL and testbench

//  Synchronous loadable down-counter/timer with start/stop/pause control and a done pulse.

---
 rtl/countdown_timer.sv | 147 ++++++++++++++
 tb/tb_countdown_timer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//
// Purpose
//   Loadable down-counter/timer with start/stop/pause control and a one-clock
//   done pulse. Software loads a count and the block counts down to zero on
//   qualified ticks. The tick input comes from an external prescaler; tie it
//   to 1 to count once per clock. Optional auto-reload turns the block into a
//   periodic event generator.
//
// Parameters
//   WIDTH        width of count, load_val and the internal reload register
//
// Ports
//   clk          in   1      system clock, rising edge
//   reset_n      in   1      reset, asynchronous assert, active low
//   start        in   1      load load_val and begin counting (level, sampled each clk)
//   stop         in   1      abort: return to IDLE, count cleared, no done
//   pause        in   1      level: hold count while high (RUN <-> HOLD)
//   tick         in   1      decrement enable (one decrement per clk with tick=1)
//   auto_reload  in   1      1: reload from reload register on expiry and keep running
//   load_val     in   WIDTH  initial/reload count, captured on an accepted start
//   count        out  WIDTH  current count value (registered)
//   busy         out  1      high in RUN or HOLD (registered)
//   done         out  1      one-clock registered pulse on expiry
//
// Per-edge priority: stop > start > pause > tick.
// ---------------------------------------------------------------------------
module countdown_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             tick,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_reg;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] reload_reg;
    logic             busy_reg;
    logic             done_reg;

    // Expiry is detected on the value 1 rather than 0 so that the edge which
    // consumes the last tick is also the edge that raises done and lands the
    // count on 0 (or the reload value). A zero count in RUN never occurs.
    logic load_is_zero;
    logic at_last;

    assign load_is_zero = (load_val == '0);
    assign at_last      = (count_reg == ONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            reload_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            // done is a pulse: cleared every edge unless expiry sets it below.
            done_reg <= 1'b0;

            if (stop) begin
                // Abort from any state; no done for an aborted run.
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
                count_reg <= '0;
            end else if (start) begin
                // Fresh start or restart from RUN/HOLD: same handling.
                count_reg  <= load_val;
                reload_reg <= load_val;
                if (load_is_zero) begin
                    // Zero-length timer expires immediately without running.
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end else begin
                    state_reg <= RUN;
                    busy_reg  <= 1'b1;
                end
            end else begin
                case (state_reg)
                    IDLE: begin
                        // tick and pause have no effect while idle.
                        state_reg <= IDLE;
                    end

                    RUN: begin
                        if (pause) begin
                            state_reg <= HOLD;
                        end else if (tick) begin
                            if (at_last) begin
                                done_reg <= 1'b1;
                                if (auto_reload) begin
                                    count_reg <= reload_reg;
                                end else begin
                                    count_reg <= '0;
                                    state_reg <= IDLE;
                                    busy_reg  <= 1'b0;
                                end
                            end else if (count_reg != '0) begin
                                // Guarded so the counter can never wrap.
                                count_reg <= count_reg - ONE;
                            end
                        end
                    end

                    HOLD: begin
                        // Leaving HOLD consumes the edge; the first decrement
                        // after resuming happens on the following tick.
                        if (!pause) begin
                            state_reg <= RUN;
                        end
                    end

                    default: begin
                        // Unreachable encoding: recover to a clean idle.
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        count_reg <= '0;
                    end
                endcase
            end
        end
    end

    assign count = count_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         pause = 1'b0;
    logic         tick = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Behavioural reference: a timer is either idle, running or held, and
    // holds a number of remaining ticks plus the period to restart with.
    int m_count  = 0;
    int m_period = 0;
    bit m_active = 0;
    bit m_held   = 0;
    bit m_done   = 0;

    countdown_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .tick       (tick),
        .auto_reload(auto_reload),
        .load_val   (load_val),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_period = 0; m_active = 0; m_held = 0; m_done = 0;
    endtask

    task automatic model_edge(input bit s, input bit sp, input bit p, input bit t,
                              input bit ar, input int lv);
        m_done = 0;
        if (sp) begin
            m_active = 0; m_held = 0; m_count = 0;
        end else if (s) begin
            m_count  = lv;
            m_period = lv;
            m_held   = 0;
            m_active = (lv != 0);
            if (lv == 0) m_done = 1;
        end else if (m_active) begin
            if (m_held) begin
                if (!p) m_held = 0;
            end else if (p) begin
                m_held = 1;
            end else if (t) begin
                m_count = m_count - 1;
                if (m_count == 0) begin
                    m_done = 1;
                    if (ar) m_count = m_period;
                    else    m_active = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"}, 32'(count), 32'(m_count));
        check({tag, ".busy"},  32'(busy),  32'(m_active));
        check({tag, ".done"},  32'(done),  32'(m_done));
        $display("%-10s start=%0b stop=%0b pause=%0b tick=%0b ar=%0b lv=%0d -> count=%0d busy=%0b done=%0b",
                 tag, start, stop, pause, tick, auto_reload, load_val, count, busy, done);
    endtask

    // One clock: drive inputs away from the edge, update the model with what
    // the edge sampled, then observe 1 time unit after the edge.
    task automatic step(input string tag, input bit s, input bit sp, input bit p,
                        input bit t, input bit ar, input int lv);
        start = s; stop = sp; pause = p; tick = t; auto_reload = ar; load_val = W'(lv);
        @(posedge clk);
        model_edge(s, sp, p, t, ar, lv);
        #1;
        check_all(tag);
    endtask

    initial begin
        int ticks;
        bit seen;

        // Reset asserted asynchronously, checked before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("reset.count", 32'(count), 32'd0);
        check("reset.busy",  32'(busy),  32'd0);
        check("reset.done",  32'(done),  32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        step("idle", 0, 0, 0, 1, 0, 0);

        // 1: load 5, tick every clock, single-shot.
        step("t1.start", 1, 0, 0, 1, 0, 5);
        check("t1.load", 32'(count), 32'd5);
        for (int i = 0; i < 5; i++) step("t1.run", 0, 0, 0, 1, 0, 0);
        check("t1.expire.done", 32'(done), 32'd1);
        check("t1.expire.busy", 32'(busy), 32'd0);
        step("t1.after", 0, 0, 0, 1, 0, 0);
        check("t1.pulse", 32'(done), 32'd0);

        // 2: auto-reload period 3.
        step("t2.start", 1, 0, 0, 1, 1, 3);
        for (int i = 0; i < 9; i++) step("t2.run", 0, 0, 0, 1, 1, 0);
        check("t2.count", 32'(count), 32'd3);
        check("t2.busy",  32'(busy),  32'd1);
        step("t2.stop", 0, 1, 0, 1, 1, 0);

        // 3: load 10, pause at count 4 for 3 clocks.
        step("t3.start", 1, 0, 0, 1, 0, 10);
        for (int i = 0; i < 6; i++) step("t3.run", 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step("t3.pause", 0, 0, 1, 1, 0, 0);
        check("t3.hold", 32'(count), 32'd4);
        step("t3.resume", 0, 0, 0, 1, 0, 0);
        check("t3.resume", 32'(count), 32'd4);
        step("t3.run", 0, 0, 0, 1, 0, 0);
        check("t3.dec", 32'(count), 32'd3);

        // 4: at count 2, start and stop together.
        step("t4.start", 1, 0, 0, 1, 0, 4);
        step("t4.run", 0, 0, 0, 1, 0, 0);
        step("t4.run", 0, 0, 0, 1, 0, 0);
        step("t4.abort", 1, 1, 0, 1, 0, 9);
        check("t4.count", 32'(count), 32'd0);
        check("t4.busy",  32'(busy),  32'd0);
        check("t4.done",  32'(done),  32'd0);

        // 5: zero-length timer.
        step("t5.start", 1, 0, 0, 1, 0, 0);
        check("t5.done", 32'(done), 32'd1);
        check("t5.busy", 32'(busy), 32'd0);
        step("t5.after", 0, 0, 0, 1, 0, 0);

        // 6: async reset mid-run at count 7, between edges.
        step("t6.start", 1, 0, 0, 1, 0, 10);
        for (int i = 0; i < 3; i++) step("t6.run", 0, 0, 0, 1, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("t6.count", 32'(count), 32'd0);
        check("t6.busy",  32'(busy),  32'd0);
        check("t6.done",  32'(done),  32'd0);
        #1 reset_n = 1'b1;
        step("t6.idle", 0, 0, 0, 1, 0, 0);

        // Maximum load: exactly 255 ticks to expiry (bounded wait).
        step("max.start", 1, 0, 0, 1, 0, 255);
        ticks = 0;
        seen  = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            step("max.run", 0, 0, 0, 1, 0, 0);
            ticks++;
            seen = done;
        end
        check("max.ticks", 32'(ticks), 32'd255);

        // Randomized control traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            bit s, sp, p, t, ar;
            int lv;
            s  = ($urandom_range(0, 19) == 0);
            sp = ($urandom_range(0, 39) == 0);
            p  = ($urandom_range(0, 5) == 0);
            t  = ($urandom_range(0, 1) == 1);
            ar = ($urandom_range(0, 2) == 0);
            lv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                               : int'($urandom_range(0, 6));
            step("rand", s, sp, p, t, ar, lv);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
